// File: rtl/audio_source_arbiter_if.sv
// Request/sample bundle between the tone requesters and the speaker-path arbiter.
// The master side drives requests and pitch; the slave side returns grant and samples.
interface audio_source_arbiter_if;
  logic        frame_tick;
  logic [2:0]  req;
  logic [9:0]  half_per_0;
  logic [9:0]  half_per_1;
  logic [9:0]  half_per_2;
  logic        mute;
  logic [2:0]  grant;
  logic [15:0] audio_left;
  logic [15:0] audio_right;

  modport master (
    output frame_tick, req, half_per_0, half_per_1, half_per_2, mute,
    input  grant, audio_left, audio_right
  );

  modport slave (
    input  frame_tick, req, half_per_0, half_per_1, half_per_2, mute,
    output grant, audio_left, audio_right
  );
endinterface

// File: rtl/audio_source_arbiter.sv
// Fixed-priority owner of the stereo speaker path; emits a square wave per audio frame.
// Grant changes only at half-period boundaries, with a minimum hold against preemption.
module audio_source_arbiter #(
  parameter logic [15:0] AMP      = 16'h2000,
  parameter int unsigned MIN_HOLD = 8
) (
  input logic                   clk,
  input logic                   rst,
  audio_source_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StPlay} state_e;

  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic        sign_q, sign_d;
  logic [9:0]  phase_q, phase_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] audio_q, audio_d;

  logic [7:0]  hold_inc;
  logic [15:0] sample;
  logic [2:0]  top_req;
  logic        owner_req;
  logic        higher_req;
  logic [9:0]  h0_eff, h1_eff, h2_eff;

  localparam logic [15:0] NegAmp = 16'(-AMP);

  function automatic logic [2:0] top_bit(input logic [2:0] r);
    if (r[2])      return 3'b100;
    else if (r[1]) return 3'b010;
    else if (r[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  function automatic logic [9:0] sel_half(input logic [2:0] g, input logic [9:0] h0,
                                          input logic [9:0] h1, input logic [9:0] h2);
    case (g)
      3'b001:  return h0;
      3'b010:  return h1;
      3'b100:  return h2;
      default: return 10'd1;
    endcase
  endfunction

  // A half-period of 0 would never reach a boundary, so it runs as 1.
  assign h0_eff = (bus.half_per_0 == 10'd0) ? 10'd1 : bus.half_per_0;
  assign h1_eff = (bus.half_per_1 == 10'd0) ? 10'd1 : bus.half_per_1;
  assign h2_eff = (bus.half_per_2 == 10'd0) ? 10'd1 : bus.half_per_2;

  assign top_req   = top_bit(bus.req);
  assign owner_req = |(bus.req & grant_q);

  always_comb begin
    case (grant_q)
      3'b001:  higher_req = |bus.req[2:1];
      3'b010:  higher_req = bus.req[2];
      default: higher_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sign_d   = sign_q;
    phase_d  = phase_q;
    hold_d   = hold_q;
    audio_d  = audio_q;
    hold_inc = (hold_q == 8'hff) ? hold_q : hold_q + 8'd1;
    sample   = 16'h0000;

    if (bus.frame_tick) begin
      unique case (state_q)
        StIdle: begin
          if (bus.req != 3'b000) begin
            grant_d = top_req;
            phase_d = sel_half(top_req, h0_eff, h1_eff, h2_eff);
            sign_d  = 1'b1;
            hold_d  = 8'd0;
            sample  = AMP;
            state_d = StPlay;
          end
        end
        StPlay: begin
          hold_d = hold_inc;
          if (phase_q > 10'd1) begin
            phase_d = phase_q - 10'd1;
            sample  = sign_q ? AMP : NegAmp;
          end else if (!owner_req && (bus.req != 3'b000)) begin
            grant_d = top_req;
            sign_d  = 1'b1;
            phase_d = sel_half(top_req, h0_eff, h1_eff, h2_eff);
            hold_d  = 8'd0;
            sample  = AMP;
          end else if (!owner_req) begin
            grant_d = 3'b000;
            state_d = StIdle;
          end else if (higher_req && (32'(hold_inc) >= MIN_HOLD)) begin
            grant_d = top_req;
            sign_d  = 1'b1;
            phase_d = sel_half(top_req, h0_eff, h1_eff, h2_eff);
            hold_d  = 8'd0;
            sample  = AMP;
          end else begin
            // Re-sample the owner's pitch so changes land on a boundary.
            sign_d  = ~sign_q;
            phase_d = sel_half(grant_q, h0_eff, h1_eff, h2_eff);
            sample  = sign_d ? AMP : NegAmp;
          end
        end
        default: state_d = StIdle;
      endcase
      audio_d = bus.mute ? 16'h0000 : sample;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= 3'b000;
      sign_q  <= 1'b1;
      phase_q <= 10'd0;
      hold_q  <= 8'd0;
      audio_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sign_q  <= sign_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      audio_q <= audio_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.audio_left  = audio_q;
  assign bus.audio_right = audio_q;

endmodule

// File: tb/tb_audio_source_arbiter.sv
// Directed bench for audio_source_arbiter: tone shape, release, hold-gated preemption,
// fallback, mute and reset, with hand-computed expected samples.
module tb_audio_source_arbiter;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  audio_source_arbiter_if bus ();

  audio_source_arbiter #(
    .AMP      (16'h2000),
    .MIN_HOLD (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; pulses frame_tick for one cycle and returns at the next negedge.
  task automatic tick();
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic tick_chk(input string tag, input logic [2:0] g, input logic [15:0] s);
    tick();
    check({tag, ".grant"}, 32'(bus.grant), 32'(g));
    check({tag, ".left"}, 32'(bus.audio_left), 32'(s));
    check({tag, ".right"}, 32'(bus.audio_right), 32'(s));
  endtask

  initial begin
    logic [15:0] tone2 [6];
    tone2 = '{16'h2000, 16'h2000, 16'hE000, 16'hE000, 16'h2000, 16'h2000};
    n_vec = 0;
    n_err = 0;
    rst            = 1'b1;
    bus.frame_tick = 1'b0;
    bus.req        = 3'b000;
    bus.half_per_0 = 10'd3;
    bus.half_per_1 = 10'd2;
    bus.half_per_2 = 10'd5;
    bus.mute       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.grant", 32'(bus.grant), 32'h0);
    check("rst.audio", 32'(bus.audio_left), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single tone, H=2.
    bus.req = 3'b010;
    for (int i = 0; i < 6; i++) tick_chk($sformatf("tone_h2[%0d]", i), 3'b010, tone2[i]);

    // Asynchronous reset mid-tone, observed before any clock edge.
    rst = 1'b1;
    #1;
    check("async_rst.grant", 32'(bus.grant), 32'h0);
    check("async_rst.left", 32'(bus.audio_left), 32'h0);
    check("async_rst.right", 32'(bus.audio_right), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.req = 3'b000;
    tick_chk("post_rst_idle", 3'b000, 16'h0000);

    // H=0 behaves as H=1, then an immediate release at the next boundary.
    bus.half_per_1 = 10'd0;
    bus.req = 3'b010;
    tick_chk("h0[0]", 3'b010, 16'h2000);
    tick_chk("h0[1]", 3'b010, 16'hE000);
    tick_chk("h0[2]", 3'b010, 16'h2000);
    tick_chk("h0[3]", 3'b010, 16'hE000);
    bus.req = 3'b000;
    tick_chk("h0_release", 3'b000, 16'h0000);

    // Release mid half-wave waits for the boundary.
    bus.half_per_1 = 10'd3;
    bus.req = 3'b010;
    tick_chk("rel[0]", 3'b010, 16'h2000);
    bus.req = 3'b000;
    tick_chk("rel[1]", 3'b010, 16'h2000);
    tick_chk("rel[2]", 3'b010, 16'h2000);
    tick_chk("rel[3]", 3'b000, 16'h0000);
    tick_chk("rel_idle", 3'b000, 16'h0000);

    // Preemption gated by MIN_HOLD: req0 H=3, req2 arrives at tick 2, wins at tick 9.
    bus.req = 3'b001;
    tick_chk("pre[0]", 3'b001, 16'h2000);
    tick_chk("pre[1]", 3'b001, 16'h2000);
    bus.req = 3'b101;
    tick_chk("pre[2]", 3'b001, 16'h2000);
    for (int i = 3; i < 6; i++) tick_chk($sformatf("pre[%0d]", i), 3'b001, 16'hE000);
    for (int i = 6; i < 9; i++) tick_chk($sformatf("pre[%0d]", i), 3'b001, 16'h2000);
    for (int i = 9; i < 14; i++) tick_chk($sformatf("pre[%0d]", i), 3'b100, 16'h2000);
    tick_chk("pre[14]", 3'b100, 16'hE000);

    // Owner req2 drops while req0 is high: fallback at the boundary.
    bus.req = 3'b001;
    for (int i = 15; i < 19; i++) tick_chk($sformatf("fb[%0d]", i), 3'b100, 16'hE000);
    tick_chk("fb[19]", 3'b001, 16'h2000);
    // A fresh hold count blocks req2 until 9 ticks after the fallback grant.
    bus.req = 3'b101;
    tick_chk("fb[20]", 3'b001, 16'h2000);
    tick_chk("fb[21]", 3'b001, 16'h2000);
    for (int i = 22; i < 25; i++) tick_chk($sformatf("fb[%0d]", i), 3'b001, 16'hE000);
    for (int i = 25; i < 28; i++) tick_chk($sformatf("fb[%0d]", i), 3'b001, 16'h2000);
    tick_chk("fb[28]", 3'b100, 16'h2000);

    // Mute zeroes the samples while phase keeps running.
    bus.mute = 1'b1;
    for (int i = 29; i < 32; i++) tick_chk($sformatf("mute[%0d]", i), 3'b100, 16'h0000);
    bus.mute = 1'b0;
    tick_chk("unmute[32]", 3'b100, 16'h2000);
    tick_chk("unmute[33]", 3'b100, 16'hE000);

    // No frame_tick: everything holds.
    bus.req = 3'b000;
    repeat (1000) @(negedge clk);
    check("notick.grant", 32'(bus.grant), 32'h4);
    check("notick.left", 32'(bus.audio_left), 32'hE000);
    check("notick.right", 32'(bus.audio_right), 32'hE000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/audio_source_arbiter.md
# audio_source_arbiter

Shares the single stereo speaker path between three tone requesters (background music, sound effect, alert) and synthesises the 16-bit sample pair that feeds the I2S speaker controller. Runs in the system clock domain and updates its sample outputs once per audio frame, on the `frame_tick` strobe derived from the speaker controller's LRCK divider. It arbitrates by fixed priority. Grant changes and releases happen only at square-wave half-period boundaries, so there are no mid-cycle clicks. A minimum hold time stops a higher-priority requester from chopping a tone that has just started.

## Interface
- `AMP`, 16'h2000, positive square-wave amplitude; the negative level is the two's complement -AMP.
- `MIN_HOLD`, 8, frames the current owner keeps the grant before a higher-priority requester may preempt.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high.
- `frame_tick`  in  1  one-cycle pulse per audio frame (one sample period).
- `req`  in  3  level requests; bit 2 has highest priority, bit 0 lowest.
- `half_per_0`, `half_per_1`, `half_per_2`  in  10 each  tone half-period in frames for each requester; 0 is treated as 1.
- `mute`  in  1  forces both sample outputs to 0; arbitration and phase keep running.
- `grant`  out  3  one-hot current owner; 0 when idle.
- `audio_left`, `audio_right`  out  16 each  two's-complement sample; both channels are always equal.

## Operation
- States: IDLE, PLAY. All decisions are taken only in a cycle where `frame_tick`=1. Without a tick, all state and outputs hold.
- Registers:
  - `sign`: 1 = positive level.
  - `phase_cnt`: 10 bits.
  - `hold_cnt`: 8 bits, saturates at 255.
  - `grant`.
- IDLE, on a tick:
  - If `req`≠0: grant the highest set bit, `phase_cnt`←H of the winner, `sign`←1, `hold_cnt`←0, sample←+AMP, go to PLAY.
  - Else sample←0.
- PLAY, on a tick, `hold_cnt` increments (saturating) first. Then:
  - If `phase_cnt`>1: `phase_cnt`−1; sample←current sign level.
  - If `phase_cnt`==1, boundary, evaluated in this order:
    - (a) Owner's `req` bit is 0 and `req`≠0: grant the highest remaining set bit, `sign`←1, reload its H, `hold_cnt`←0, sample←+AMP.
    - (b) Owner's `req` bit is 0 and `req`==0: `grant`←0, sample←0, go to IDLE.
    - (c) A higher-priority bit is set and `hold_cnt`≥MIN_HOLD: switch to the highest set bit, `sign`←1, reload, `hold_cnt`←0, sample←+AMP.
    - (d) Otherwise: `sign` toggles, `phase_cnt`←the owner's current H (re-sampled, so pitch changes take effect here), sample←the new sign level.
- Result: each half-wave lasts exactly H ticks, counting the entry tick.
- Sample level is +AMP or −AMP. `mute`=1 makes the registered sample 0 on that tick; the FSM is unaffected.
- A request dropping mid half-wave does not shorten the tone; release waits for the boundary.

## Timing
- Outputs are registered and change on the clock edge that samples `frame_tick`=1. They are valid from the next cycle.
- Latency from a request to the first non-zero sample is 1 tick. Idle→PLAY never waits for a boundary.
- Preemption latency is at most the current half-period, and never earlier than MIN_HOLD ticks after the owner was granted.
- Reset, asynchronous and possible at any point including mid-tone, sets: IDLE, `grant`=0, `audio_left`=`audio_right`=0, `phase_cnt`=0, `hold_cnt`=0, `sign`=1. The first tick after release behaves as IDLE.
- `frame_tick` coincident with a `req` change: the value of `req` in that cycle is the one used.

## Test plan
- Reset: assert `rst` mid-PLAY with no clock edge → `grant`=0 and both outputs 0 immediately. After release, the first tick with `req`=0 keeps the outputs at 0.
- Single tone: `req`=3'b010, `half_per_1`=2 → ticks 0..5 give samples 2000, 2000, E000, E000, 2000, 2000 (hex); `grant`=3'b010 throughout. With `half_per_1`=0 → 2000, E000, 2000 alternating.
- Release: drop `req` at tick 1 with H=3 → samples stay at 2000 through tick 2. At tick 3 the sample is 0000, `grant`=0, and the block is in IDLE.
- Preemption with hold: `req0` plays with H=3 and MIN_HOLD=8; `req2` asserts at tick 2 → the grant switches to 3'b100 at tick 9, not at tick 3 or 6. The sample at tick 9 is 2000 and the new H is loaded.
- Fallback on release: owner `req2` drops while `req0` is still high → at the next boundary `grant` becomes 3'b001, sign is positive, and `hold_cnt` is 0.
- Mute/no-tick: `mute`=1 during PLAY → outputs are 0000 while `grant` and phase continue; on unmute the level follows the phase sequence. With 1000 cycles and no `frame_tick`, the outputs stay unchanged.
